// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage program counter: legacy chip-enable /
// reset macros, the address bus macro, the FSM state encoding and an alignment helper.
`ifndef PC_GEN_DEFINES_SVH
`define PC_GEN_DEFINES_SVH
`define RstEnable   1'b1
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define InstAddrBus 31:0
`endif

package pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_RUN  = 2'b01,
        PC_HOLD = 2'b10
    } pc_state_e;

    // Mask that clears the low log2(inst_bytes) address bits; inst_bytes is a power of two.
    function automatic logic [63:0] align_mask(input int inst_bytes);
        return ~(64'(inst_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one branch target captured while the pipeline is stalled; a later
// capture overwrites the stored target, and clear wins over capture.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] pend_addr_o,
    output logic              pend_valid_o
);

    logic [ADDR_W-1:0] pend_addr_q;
    logic              pend_valid_q;

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
        end else if (clear_i) begin
            pend_valid_q <= 1'b0;
        end else if (capture_i) begin
            pend_addr_q  <= addr_i;
            pend_valid_q <= 1'b1;
        end
    end

    assign pend_addr_o  = pend_addr_q;
    assign pend_valid_o = pend_valid_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with stall hold, buffered branch redirect and flush.
// Define PC_GEN_PERF_EN to add saturating fetch/stall/redirect counters.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                INST_BYTES   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_pending
`ifdef PC_GEN_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       redirect_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INST_BYTES));
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              ce_q;

    logic [ADDR_W-1:0] flush_tgt;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_valid;
    logic              active;
    logic              pend_capture;
    logic              pend_clear;
    logic              pc_load;

    assign flush_tgt  = new_pc & ALIGN_MASK;
    assign branch_tgt = branch_target_address_i & ALIGN_MASK;
    assign active     = (state_q == PC_RUN) || (state_q == PC_HOLD);

    // Flush discards the buffer; releasing the stall consumes it (a fresh branch
    // in that same cycle still wins over the buffered target).
    assign pend_capture = active && !flush && stall && branch_flag_i;
    assign pend_clear   = active && (flush || (!stall && pend_valid));
    assign pc_load      = active && (flush || (!stall && (pend_valid || branch_flag_i)));

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pend_clear),
        .capture_i    (pend_capture),
        .addr_i       (branch_tgt),
        .pend_addr_o  (pend_addr),
        .pend_valid_o (pend_valid)
    );

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            state_q <= PC_BOOT;
            ce_q    <= `ChipDisable;
            pc_q    <= RESET_VECTOR;
        end else begin
            case (state_q)
                PC_BOOT: begin
                    // First enabled fetch is the reset vector itself.
                    state_q <= PC_RUN;
                    ce_q    <= `ChipEnable;
                    pc_q    <= RESET_VECTOR;
                end
                PC_RUN, PC_HOLD: begin
                    ce_q <= `ChipEnable;
                    if (flush) begin
                        pc_q    <= flush_tgt;
                        state_q <= PC_RUN;
                    end else if (stall) begin
                        if (branch_flag_i) begin
                            state_q <= PC_HOLD;
                        end
                    end else if (pend_valid) begin
                        pc_q    <= branch_flag_i ? branch_tgt : pend_addr;
                        state_q <= PC_RUN;
                    end else if (branch_flag_i) begin
                        pc_q <= branch_tgt;
                    end else begin
                        pc_q <= pc_q + PC_INC;
                    end
                end
                default: begin
                    state_q <= PC_BOOT;
                    ce_q    <= `ChipDisable;
                    pc_q    <= RESET_VECTOR;
                end
            endcase
        end
    end

    assign pc               = pc_q;
    assign ce               = ce_q;
    assign redirect_pending = pend_valid;

`ifdef PC_GEN_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [15:0] redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            fetch_cnt_q    <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (ce_q == `ChipEnable && !stall && fetch_cnt_q != '1) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ce_q == `ChipEnable && stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (pc_load && redirect_cnt_q != '1) begin
                redirect_cnt_q <= redirect_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_cnt    = fetch_cnt_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus randomized check of pc_gen against a behavioural model of the
// fetch address, enable and pending-redirect flag; a second instance covers wrap.
module tb_pc_gen;

    localparam logic [31:0] WRAP_RV = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, branch;
    logic [31:0] new_pc, btgt;
    logic [31:0] pc;
    logic        ce, rp;

    logic        rst_w;
    logic        zero1  = 1'b0;
    logic [31:0] zero32 = 32'd0;
    logic [31:0] pc_w;
    logic        ce_w, rp_w;

`ifdef PC_GEN_PERF_EN
    logic [31:0] fc, sc, fc_w, sc_w;
    logic [15:0] rc, rc_w;
`endif

    pc_gen #(
        .ADDR_W       (32),
        .RESET_VECTOR (32'h0),
        .INST_BYTES   (4)
    ) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch),
        .branch_target_address_i (btgt),
        .pc                      (pc),
        .ce                      (ce),
        .redirect_pending        (rp)
`ifdef PC_GEN_PERF_EN
        ,
        .fetch_cnt               (fc),
        .stall_cnt               (sc),
        .redirect_cnt            (rc)
`endif
    );

    pc_gen #(
        .ADDR_W       (32),
        .RESET_VECTOR (WRAP_RV),
        .INST_BYTES   (4)
    ) u_wrap (
        .clk                     (clk),
        .rst                     (rst_w),
        .stall                   (zero1),
        .flush                   (zero1),
        .new_pc                  (zero32),
        .branch_flag_i           (zero1),
        .branch_target_address_i (zero32),
        .pc                      (pc_w),
        .ce                      (ce_w),
        .redirect_pending        (rp_w)
`ifdef PC_GEN_PERF_EN
        ,
        .fetch_cnt               (fc_w),
        .stall_cnt               (sc_w),
        .redirect_cnt            (rc_w)
`endif
    );

    // Behavioural model: fetching flag, current address, queue of at most one pending target.
    bit          m_fetching;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_fetching = 1'b0;
            m_pc       = 32'h0;
            m_pend.delete();
        end else if (!m_fetching) begin
            m_fetching = 1'b1;
        end else if (flush) begin
            m_pc = aligned(new_pc);
            m_pend.delete();
        end else if (stall) begin
            if (branch) begin
                m_pend.delete();
                m_pend.push_back(aligned(btgt));
            end
        end else if (m_pend.size() != 0) begin
            m_pc = branch ? aligned(btgt) : m_pend[0];
            m_pend.delete();
        end else if (branch) begin
            m_pc = aligned(btgt);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_ce"}, 32'(ce), 32'(m_fetching));
        check({tag, "_pend"}, 32'(rp), 32'(m_pend.size() != 0));
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] np,
                         input logic b, input logic [31:0] bt);
        rst = r; stall = s; flush = f; new_pc = np; branch = b; btgt = bt;
    endtask

    initial begin
        rst_w = 1'b1;
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("reset");
        check("reset_ce_const", 32'(ce), 32'd0);
        check("reset_pc_const", pc, 32'h0);
        check("wrap_reset_pc", pc_w, WRAP_RV);
        check("wrap_reset_ce", 32'(ce_w), 32'd0);

        // Release: first fetch at the reset vector, then sequential.
        rst_w = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        step("boot");
        check("first_fetch", pc, 32'h0);
        check("first_ce", 32'(ce), 32'd1);
        check("wrap_first", pc_w, WRAP_RV);
        step("seq1");
        check("seq_4", pc, 32'h4);
        check("wrap_second", pc_w, 32'hFFFF_FFFC);
        step("seq2");
        check("seq_8", pc, 32'h8);
        check("wrap_to_zero", pc_w, 32'h0);
        step("seq3");
        check("seq_c", pc, 32'hC);
        step("seq4");
        check("seq_10", pc, 32'h10);

        // Two-cycle stall holds the PC.
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        step("stall1");
        step("stall2");
        check("stall_hold", pc, 32'h10);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        step("unstall");
        check("after_stall", pc, 32'h14);

        // Branch arriving during a stall is buffered until release.
        drive(0, 1, 0, 32'h0, 1, 32'h200);
        step("buf_br");
        check("buf_pending", 32'(rp), 32'd1);
        check("buf_hold", pc, 32'h14);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        step("buf_rel");
        check("buf_target", pc, 32'h200);
        check("buf_cleared", 32'(rp), 32'd0);

        // Flush beats stall and a simultaneous branch.
        drive(0, 1, 1, 32'h20, 1, 32'h300);
        step("flush");
        check("flush_pc", pc, 32'h20);
        check("flush_nopend", 32'(rp), 32'd0);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        step("post_flush");
        check("post_flush_pc", pc, 32'h24);

        // Unaligned redirect targets are forced to instruction alignment.
        drive(0, 0, 0, 32'h0, 1, 32'h1003);
        step("align_br");
        check("align_branch", pc, 32'h1000);
        drive(0, 0, 1, 32'h57, 0, 32'h0);
        step("align_fl");
        check("align_flush", pc, 32'h54);

        // Reset while a redirect is pending discards it.
        drive(0, 1, 0, 32'h0, 1, 32'h400);
        step("hold400");
        check("hold_pending", 32'(rp), 32'd1);
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        step("mid_rst");
        check("midrst_ce", 32'(ce), 32'd0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_pend", 32'(rp), 32'd0);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        step("rerel");
        check("rerel_pc", pc, 32'h0);
        step("rerel2");
        check("rerel_not400", pc, 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(99) < 2, $urandom_range(99) < 35, $urandom_range(99) < 6,
                  $urandom, $urandom_range(99) < 25, $urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the fetch-stage program counter.
- Generates the instruction fetch address and the fetch chip-enable for the IF stage.
- Adds the following over a plain free-running PC:
  - configurable address width, reset vector and instruction size;
  - pipeline stall hold;
  - branch redirect, including buffering of a branch that arrives during a stall;
  - exception flush redirect.
- Sits between the control/ID stages (stall, branch, flush sources) and instruction ROM/IF-ID register.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VECTOR, 0, fetch address held during reset and issued on the first enabled cycle.
- INST_BYTES, 4, PC increment per fetch; power of two, 1..8.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- stall  input  1  hold PC this cycle (from ctrl)
- flush  input  1  exception/eret redirect
- new_pc  input  ADDR_W  flush target
- branch_flag_i  input  1  branch/jump taken (from ID)
- branch_target_address_i  input  ADDR_W  branch target
- pc  output  ADDR_W  fetch address
- ce  output  1  fetch enable (`ChipEnable/`ChipDisable)
- redirect_pending  output  1  a branch captured during stall awaits release

Behaviour:
- Internal state FSM:
  - BOOT: ce disabled.
  - RUN: normal fetch.
  - HOLD: stalled with a buffered branch.
- Internal registers: pend_addr[ADDR_W], pend_valid.
- Reset (rst=1 at posedge clk): state<=BOOT, ce<=`ChipDisable, pc<=RESET_VECTOR, pend_valid<=0, redirect_pending<=0. Overrides every other input.
- BOOT: pc held at RESET_VECTOR. First posedge with rst=0 gives ce<=`ChipEnable and state<=RUN; pc stays RESET_VECTOR, so the first enabled fetch is RESET_VECTOR. stall/branch/flush are ignored in BOOT.
- RUN/HOLD next-PC priority, highest first, evaluated each posedge:
  1. flush=1: pc<=new_pc; pend_valid<=0; state<=RUN. Applies even if stall=1.
  2. stall=1: pc holds. If branch_flag_i=1, pend_addr<=branch_target_address_i, pend_valid<=1 and state<=HOLD; a later branch during the same stall overwrites pend_addr (latest wins).
  3. stall=0 and pend_valid=1: pc<=pend_addr; pend_valid<=0; state<=RUN. A simultaneous branch_flag_i takes precedence: pc<=branch_target_address_i, pend cleared.
  4. stall=0 and branch_flag_i=1: pc<=branch_target_address_i.
  5. Otherwise: pc<=pc+INST_BYTES, modulo 2^ADDR_W. Max address wraps to 0 with no flag.
- Alignment: the low log2(INST_BYTES) bits of new_pc and the branch target are forced to 0 before loading.
- redirect_pending is a registered copy of pend_valid.
- Latency: redirects take effect on the pc one cycle after the inputs are sampled. No combinational input-to-output paths.
- Reset mid-operation: discards any pending redirect and returns to BOOT within one cycle.

Optional Feature:
- Macro PC_GEN_PERF_EN.
- When defined, adds outputs:
  - fetch_cnt[31:0]: increments every cycle with ce enabled and stall=0.
  - stall_cnt[31:0]: increments every cycle with ce enabled and stall=1.
  - redirect_cnt[15:0]: increments on each pc load from flush, branch or pending.
- All three counters reset to 0 and saturate at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared defines file: `ChipEnable, `ChipDisable, `RstEnable, `InstAddrBus, and the FSM state encodings (PC_BOOT, PC_RUN, PC_HOLD).
- One natural sub-module, pc_redirect_buf: holds pend_addr/pend_valid with capture/overwrite/clear rules.
- Perf counters stay inline under the macro.

Test Plan (defaults unless stated):
- Reset release: rst=1 for 3 cycles, then 0 -> ce=0 and pc=0 during reset; ce=1 with pc=0x0 first; then 0x4, 0x8, 0xC on consecutive cycles.
- Stall: stall=1 for 2 cycles at pc=0x10 -> pc holds 0x10; pc=0x14 one cycle after release.
- Branch buffered in stall: stall=1, branch_flag_i=1 target 0x200 -> redirect_pending=1, pc holds; stall=0 -> pc=0x200, redirect_pending=0.
- Flush priority: stall=1, branch_flag_i=1 target 0x300, flush=1 new_pc=0x20 together -> pc=0x20, no pending; then 0x24.
- Wrap: RESET_VECTOR=0xFFFFFFF8 -> pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Reset mid-HOLD: pending 0x400, then rst=1 -> ce=0, pc=RESET_VECTOR, pending cleared; after release the fetch starts at RESET_VECTOR, not 0x400.
